// File: rtl/vending_pkg.sv
// Shared types and recipe table for the parametrised coffee vending controller.
// Ingredient masks use bit0=agua .. bit4=azucar.
package vending_pkg;

  localparam int NUM_PROD  = 4;
  localparam int NUM_ING   = 5;
  localparam int NUM_STEPS = 3;
  localparam int PROD_W    = $clog2(NUM_PROD);
  localparam int STEP_W    = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  typedef logic [NUM_ING-1:0] ing_mask_t;
  typedef logic [PROD_W-1:0]  prod_idx_t;
  typedef logic [STEP_W-1:0]  step_idx_t;

  localparam int ING_AGUA      = 0;
  localparam int ING_CAFE      = 1;
  localparam int ING_LECHE     = 2;
  localparam int ING_CHOCOLATE = 3;
  localparam int ING_AZUCAR    = 4;

  localparam ing_mask_t M_AGUA      = ing_mask_t'(1 << ING_AGUA);
  localparam ing_mask_t M_CAFE      = ing_mask_t'(1 << ING_CAFE);
  localparam ing_mask_t M_LECHE     = ing_mask_t'(1 << ING_LECHE);
  localparam ing_mask_t M_CHOCOLATE = ing_mask_t'(1 << ING_CHOCOLATE);
  localparam ing_mask_t M_AZUCAR    = ing_mask_t'(1 << ING_AZUCAR);

  // A zero mask terminates a recipe early (expreso has only two steps).
  localparam ing_mask_t RECIPE [NUM_PROD][NUM_STEPS] = '{
    '{M_AGUA | M_CAFE,      M_AZUCAR, '0},
    '{M_AGUA | M_CAFE,      M_LECHE,  M_AZUCAR},
    '{M_CAFE | M_LECHE,     M_LECHE,  M_AZUCAR},
    '{M_CAFE | M_CHOCOLATE, M_LECHE,  M_AZUCAR}
  };

  function automatic ing_mask_t recipe_mask(input prod_idx_t prod, input step_idx_t step);
    if ({1'b0, step} < (STEP_W + 1)'(NUM_STEPS))
      return RECIPE[prod][step];
    return '0;
  endfunction

endpackage

// File: rtl/vending_fsm_param_if.sv
// Panel-side signal bundle of the vending controller: coin/cancel/select in,
// credit, change, ingredient mask and status pulses out.
interface vending_fsm_param_if #(
  parameter int N_PROD   = 4,
  parameter int N_ING    = 5,
  parameter int CREDIT_W = 4
);
  logic                coin1;
  logic                coin2;
  logic                cancel;
  logic [N_PROD-1:0]   sel;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] change;
  logic [N_ING-1:0]    ingr;
  logic                busy;
  logic                coin_rej;
  logic                done;

  modport master (
    output coin1, coin2, cancel, sel,
    input  credit, change, ingr, busy, coin_rej, done
  );

  modport slave (
    input  coin1, coin2, cancel, sel,
    output credit, change, ingr, busy, coin_rej, done
  );
endinterface

// File: rtl/step_timer.sv
// Down-counter that pulses expire for one clock CNT_MAX clocks after load.
// load wins over counting so a new interval can start on the expire cycle.
module step_timer #(
  parameter int CNT_MAX = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(CNT_MAX) + 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CNT_MAX - 1);

  logic [W-1:0] cnt;
  logic         active;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= LOAD_VAL;
      active <= 1'b1;
    end else if (en && active) begin
      if (cnt == '0)
        active <= 1'b0;
      else
        cnt <= cnt - W'(1);
    end
  end

  assign expire = en && active && (cnt == '0);

endmodule

// File: rtl/vending_fsm_param.sv
// Coin-operated coffee controller: collects credit, runs a timed multi-step
// recipe for the selected product and shows change before returning to idle.
module vending_fsm_param
  import vending_pkg::*;
#(
  parameter int                          N_PROD      = 4,
  parameter int                          N_ING       = 5,
  parameter int                          N_STEPS     = 3,
  parameter int                          CREDIT_W    = 4,
  parameter int                          COIN1_VAL   = 1,
  parameter int                          COIN2_VAL   = 2,
  parameter logic [N_PROD*CREDIT_W-1:0]  PRICES      = {4'd4, 4'd3, 4'd3, 4'd2},
  parameter int                          T_STEP      = 50000,
  parameter int                          CHANGE_HOLD = 100000
) (
  input logic                clk,
  input logic                rst,
  vending_fsm_param_if.slave bus
);
  localparam int IN_W = N_PROD + 3;
  localparam int CW1  = CREDIT_W + 1;
  localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W:0] C1 = CW1'(COIN1_VAL);
  localparam logic [CREDIT_W:0] C2 = CW1'(COIN2_VAL);

  logic [IN_W-1:0] in_cur;
  logic [IN_W-1:0] in_prev;
  logic [IN_W-1:0] in_edge;

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_q;
  logic [N_ING-1:0]    ingr_q;
  logic                busy_q;
  logic                coin_rej_q;
  logic                done_q;
  prod_idx_t           prod_q;
  step_idx_t           step_q;

  logic                coin1_edge, coin2_edge, cancel_edge, sel_edge, coin_edge_any;
  logic [N_PROD-1:0]   sel_r;
  prod_idx_t           sel_idx;
  logic                sel_valid;
  logic [CREDIT_W-1:0] price_sel;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok, coin_bad;
  step_idx_t           step_next;
  logic                last_step;
  logic                waiting, start_dispense, step_advance, finish_recipe;
  logic                step_load, hold_load, step_expire, hold_expire;

  // One register stage on every panel input, plus one more for edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cur  <= '0;
      in_prev <= '0;
    end else begin
      in_cur  <= {bus.sel, bus.cancel, bus.coin2, bus.coin1};
      in_prev <= in_cur;
    end
  end

  assign in_edge       = in_cur & ~in_prev;
  assign coin1_edge    = in_edge[0];
  assign coin2_edge    = in_edge[1];
  assign cancel_edge   = in_edge[2];
  assign sel_edge      = |in_edge[IN_W-1:3];
  assign sel_r         = in_cur[IN_W-1:3];
  assign coin_edge_any = coin1_edge | coin2_edge;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_PROD; i++)
      if (sel_r[i]) sel_idx = prod_idx_t'(i);
  end

  assign price_sel = PRICES[sel_idx*CREDIT_W +: CREDIT_W];
  assign sel_valid = $onehot(sel_r) && (credit_q >= price_sel);

  // Coins are accepted one at a time so a rejected coin1 cannot block coin2.
  always_comb begin
    coin_sum = {1'b0, credit_q};
    coin_ok  = 1'b0;
    coin_bad = 1'b0;
    if (coin1_edge) begin
      if (coin_sum + C1 <= CREDIT_MAX) begin
        coin_sum = coin_sum + C1;
        coin_ok  = 1'b1;
      end else begin
        coin_bad = 1'b1;
      end
    end
    if (coin2_edge) begin
      if (coin_sum + C2 <= CREDIT_MAX) begin
        coin_sum = coin_sum + C2;
        coin_ok  = 1'b1;
      end else begin
        coin_bad = 1'b1;
      end
    end
  end

  assign step_next      = step_q + step_idx_t'(1);
  assign last_step      = (step_q == step_idx_t'(N_STEPS - 1)) ||
                          (recipe_mask(prod_q, step_next) == '0);
  assign waiting        = (state == IDLE) || (state == COLLECT);
  assign start_dispense = waiting && !cancel_edge && !coin_edge_any && sel_edge && sel_valid;
  assign step_advance   = (state == DISPENSE) && step_expire && !last_step;
  assign finish_recipe  = (state == DISPENSE) && step_expire && last_step;
  assign step_load      = start_dispense || step_advance;
  assign hold_load      = ((state == COLLECT) && cancel_edge) ||
                          (finish_recipe && (change_q != '0));

  step_timer #(.CNT_MAX(T_STEP)) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (step_load),
    .en     (state == DISPENSE),
    .expire (step_expire)
  );

  step_timer #(.CNT_MAX(CHANGE_HOLD)) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (hold_load),
    .en     (state == CHANGE),
    .expire (hold_expire)
  );

  // Per-cycle priority while waiting for a purchase: cancel, then coins, then select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      credit_q   <= '0;
      change_q   <= '0;
      ingr_q     <= '0;
      busy_q     <= 1'b0;
      coin_rej_q <= 1'b0;
      done_q     <= 1'b0;
      prod_q     <= '0;
      step_q     <= '0;
    end else begin
      coin_rej_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (cancel_edge) begin
            coin_rej_q <= coin_edge_any;
            if (state == COLLECT) begin
              change_q <= credit_q;
              credit_q <= '0;
              state    <= CHANGE;
              busy_q   <= 1'b1;
            end
          end else if (coin_edge_any) begin
            credit_q   <= coin_sum[CREDIT_W-1:0];
            coin_rej_q <= coin_bad;
            if (coin_ok) state <= COLLECT;
          end else if (start_dispense) begin
            prod_q   <= sel_idx;
            step_q   <= '0;
            change_q <= credit_q - price_sel;
            credit_q <= '0;
            ingr_q   <= N_ING'(recipe_mask(sel_idx, '0));
            state    <= DISPENSE;
            busy_q   <= 1'b1;
          end
        end
        DISPENSE: begin
          coin_rej_q <= coin_edge_any;
          if (step_advance) begin
            step_q <= step_next;
            ingr_q <= N_ING'(recipe_mask(prod_q, step_next));
          end else if (finish_recipe) begin
            ingr_q <= '0;
            done_q <= 1'b1;
            if (change_q != '0) begin
              state <= CHANGE;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        CHANGE: begin
          coin_rej_q <= coin_edge_any;
          if (hold_expire) begin
            change_q <= '0;
            state    <= IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.credit   = credit_q;
  assign bus.change   = change_q;
  assign bus.ingr     = ingr_q;
  assign bus.busy     = busy_q;
  assign bus.coin_rej = coin_rej_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Scoreboard bench for vending_fsm_param: a queue-based purchase model predicts
// every cycle's outputs; a monitor pops and compares them after each clock edge.
module tb_vending_fsm_param;

  localparam int T_STEP      = 4;
  localparam int CHANGE_HOLD = 3;
  localparam int MAX_CREDIT  = 15;

  localparam int AGUA = 1, CAFE = 2, LECHE = 4, CHOC = 8, AZUCAR = 16;
  localparam int RECIPE_TB [4][3] = '{
    '{AGUA + CAFE,  AZUCAR, 0},
    '{AGUA + CAFE,  LECHE,  AZUCAR},
    '{CAFE + LECHE, LECHE,  AZUCAR},
    '{CAFE + CHOC,  LECHE,  AZUCAR}
  };
  localparam int PRICE_TB [4] = '{2, 3, 3, 4};

  typedef struct {
    int credit;
    int change;
    int ingr;
    bit busy;
    bit rej;
    bit done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state
  int        m_credit, m_change, m_ingr, hold_left;
  bit        m_rej, m_done, dispensing;
  int        mask_q[$];
  logic [6:0] smp_now, smp_old;

  vending_fsm_param_if #(.N_PROD(4), .N_ING(5), .CREDIT_W(4)) bus ();

  vending_fsm_param #(.T_STEP(T_STEP), .CHANGE_HOLD(CHANGE_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    m_credit = 0; m_change = 0; m_ingr = 0; hold_left = 0;
    m_rej = 0; m_done = 0; dispensing = 0;
    mask_q.delete();
    smp_now = '0; smp_old = '0;
  endfunction

  // Advances the model by one clock edge given the inputs sampled at that edge.
  function automatic void modelStep(logic c1, logic c2, logic cn, logic [3:0] s, logic r);
    logic [6:0] e;
    logic [3:0] sv;
    bit         anycoin;
    int         idx;
    exp_t       x;
    if (r) begin
      modelReset();
    end else begin
      e   = smp_now & ~smp_old;
      sv  = smp_now[6:3];
      smp_old = smp_now;
      smp_now = {s, cn, c2, c1};
      anycoin = e[0] | e[1];
      m_rej = 0; m_done = 0;
      if (dispensing) begin
        m_rej = anycoin;
        if (mask_q.size() > 0) begin
          m_ingr = mask_q.pop_front();
        end else begin
          dispensing = 0; m_ingr = 0; m_done = 1;
          if (m_change > 0) hold_left = CHANGE_HOLD;
        end
      end else if (hold_left > 0) begin
        m_rej = anycoin;
        hold_left--;
        if (hold_left == 0) m_change = 0;
      end else if (e[2]) begin
        m_rej = anycoin;
        if (m_credit > 0) begin
          m_change = m_credit; m_credit = 0; hold_left = CHANGE_HOLD;
        end
      end else if (anycoin) begin
        if (e[0]) begin
          if (m_credit + 1 <= MAX_CREDIT) m_credit += 1; else m_rej = 1;
        end
        if (e[1]) begin
          if (m_credit + 2 <= MAX_CREDIT) m_credit += 2; else m_rej = 1;
        end
      end else if (e[6:3] != 0 && $countones(sv) == 1) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (sv[i]) idx = i;
        if (m_credit >= PRICE_TB[idx]) begin
          m_change = m_credit - PRICE_TB[idx];
          m_credit = 0;
          for (int st = 0; st < 3 && RECIPE_TB[idx][st] != 0; st++)
            repeat (T_STEP) mask_q.push_back(RECIPE_TB[idx][st]);
          m_ingr = mask_q.pop_front();
          dispensing = 1;
        end
      end
    end
    x.credit = m_credit; x.change = m_change; x.ingr = m_ingr;
    x.busy = dispensing || (hold_left > 0);
    x.rej = m_rej; x.done = m_done;
    exp_q.push_back(x);
  endfunction

  task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t x);
    checkField("credit",   8'(bus.credit),   8'(x.credit));
    checkField("change",   8'(bus.change),   8'(x.change));
    checkField("ingr",     8'(bus.ingr),     8'(x.ingr));
    checkField("busy",     8'(bus.busy),     8'(x.busy));
    checkField("coin_rej", 8'(bus.coin_rej), 8'(x.rej));
    checkField("done",     8'(bus.done),     8'(x.done));
  endtask

  // Holds one input pattern for a number of cycles, logging each edge's expectation.
  task automatic applyStimulus(input logic c1, input logic c2, input logic cn,
                               input logic [3:0] s, input logic r, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.coin1 = c1; bus.coin2 = c2; bus.cancel = cn; bus.sel = s; rst = r;
      modelStep(c1, c2, cn, s, r);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle(input int cycles);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, cycles);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput(x);
      end
    end
  end

  initial begin : driver
    logic       c1, c2, cn, r;
    logic [3:0] s;
    modelReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 3);
    idle(2);

    $display("[TB] scenario 1: expreso with change");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1); idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1); idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1); idle(18);

    $display("[TB] scenario 2: insufficient credit then cancel");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1); idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 2); idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1); idle(8);

    $display("[TB] scenario 3: credit saturation");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1); idle(1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1); idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1); idle(8);

    $display("[TB] scenario 4: multi-hot select then cappuccino");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1); idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1); idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 2); idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1); idle(20);

    $display("[TB] scenario 5: coins and cancel while dispensing, then reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1); idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1); idle(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1); idle(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1); idle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1); idle(4);

    $display("[TB] scenario 6: coin and cancel in the same cycle");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1); idle(2);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1); idle(8);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      c1 = ($urandom_range(0, 3) == 0);
      c2 = ($urandom_range(0, 3) == 0);
      cn = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 9))
        0, 1:    s = 4'(1 << $urandom_range(0, 3));
        2:       s = 4'($urandom_range(0, 15));
        default: s = 4'b0000;
      endcase
      applyStimulus(c1, c2, cn, s, r, $urandom_range(1, 3));
    end
    idle(20);

    for (int g = 0; g < 10 && exp_q.size() > 0; g++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
